// File: rtl/sss_pkg.sv
// sss_pkg: shared SSS constants and the peak-detector state encoding.
//   SSS_LEN  - SSS sequence length
//   NUM_NID1 - number of cell-ID group hypotheses
//   CORR_W   - correlation metric width
//   IDX_W    - hypothesis index width
package sss_pkg;
    localparam int SSS_LEN  = 62;
    localparam int NUM_NID1 = 168;
    localparam int CORR_W   = 32;
    localparam int IDX_W    = 8;
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
endpackage

// File: rtl/sss_peak_detector_if.sv
// sss_peak_detector_if: control, correlator and result signals of the peak detector.
//   master - search controller / correlator side (drives start, threshold, correlation inputs)
//   slave  - peak detector side (drives hyp_idx, status and results)
interface sss_peak_detector_if #(
    parameter int CORR_W = 32,
    parameter int IDX_W  = 8
);
    logic              start;
    logic [CORR_W-1:0] threshold;
    logic              corr_valid;
    logic [CORR_W-1:0] correlation_result;
    logic [IDX_W-1:0]  hyp_idx;
    logic              busy;
    logic              done;
    logic              found;
    logic [IDX_W-1:0]  best_idx;
    logic [CORR_W-1:0] best_metric;
    logic [CORR_W-1:0] second_metric;
    modport master (
        output start, threshold, corr_valid, correlation_result,
        input  hyp_idx, busy, done, found, best_idx, best_metric, second_metric
    );
    modport slave (
        input  start, threshold, corr_valid, correlation_result,
        output hyp_idx, busy, done, found, best_idx, best_metric, second_metric
    );
endinterface

// File: rtl/sss_peak_tracker.sv
// sss_peak_tracker: keeps the largest and second-largest metric and the index of the largest.
//   clk, reset       - clock, synchronous active-high reset
//   clear            - start a fresh tracking run (all registers to 0)
//   upd, value, idx  - one metric sample and its hypothesis index
//   best, second, best_idx - tracked results
module sss_peak_tracker #(
    parameter int CORR_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              upd,
    input  logic [CORR_W-1:0] value,
    input  logic [IDX_W-1:0]  idx,
    output logic [CORR_W-1:0] best,
    output logic [CORR_W-1:0] second,
    output logic [IDX_W-1:0]  best_idx
);
    logic [CORR_W-1:0] best_q, best_d, second_q, second_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              gt_best, mid;
    // A value equal to the current best is neither a new peak nor a runner-up,
    // so ties keep the lower index and a repeated peak does not fill second.
    always_comb begin
        gt_best  = upd && value > best_q;
        mid      = upd && value < best_q && value > second_q;
        best_d   = clear ? '0 : gt_best ? value : best_q;
        idx_d    = clear ? '0 : gt_best ? idx : idx_q;
        second_d = clear ? '0 : gt_best ? best_q : mid ? value : second_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            best_q   <= '0;
            second_q <= '0;
            idx_q    <= '0;
        end else begin
            best_q   <= best_d;
            second_q <= second_d;
            idx_q    <= idx_d;
        end
    end
    assign best     = best_q;
    assign second   = second_q;
    assign best_idx = idx_q;
endmodule

// File: rtl/sss_peak_detector.sv
// sss_peak_detector: steps the SSS correlator through all hypotheses and reports the peak.
//   clk, reset - clock, synchronous active-high reset
//   bus        - slave side of sss_peak_detector_if: start/threshold in, correlator
//                handshake (hyp_idx out, corr_valid/correlation_result in), results out
module sss_peak_detector
    import sss_pkg::*;
#(
    parameter int NUM_HYP = NUM_NID1,
    parameter int CORR_W  = sss_pkg::CORR_W,
    parameter int IDX_W   = sss_pkg::IDX_W
) (
    input logic                 clk,
    input logic                 reset,
    sss_peak_detector_if.slave  bus
);
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  hyp_q, hyp_d;
    logic [CORR_W-1:0] thr_q, thr_d;
    logic              found_q, found_d;
    logic [CORR_W-1:0] best, second;
    logic [IDX_W-1:0]  best_idx;
    logic              clear, accept, last, hit;
    always_comb begin
        clear   = state_q == IDLE && bus.start;
        accept  = state_q == SEARCH && bus.corr_valid;
        last    = hyp_q == IDX_W'(NUM_HYP - 1);
        hit     = best >= thr_q && best > second;
        state_d = clear ? SEARCH : (accept && last) ? DONE : state_q == DONE ? IDLE : state_q;
        hyp_d   = clear ? '0 : (accept && !last) ? hyp_q + 1'b1 : hyp_q;
        thr_d   = clear ? bus.threshold : thr_q;
        found_d = clear ? 1'b0 : state_q == DONE ? hit : found_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hyp_q   <= '0;
            thr_q   <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hyp_q   <= hyp_d;
            thr_q   <= thr_d;
            found_q <= found_d;
        end
    end
    sss_peak_tracker #(.CORR_W(CORR_W), .IDX_W(IDX_W)) u_tracker (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .upd      (accept),
        .value    (bus.correlation_result),
        .idx      (hyp_q),
        .best     (best),
        .second   (second),
        .best_idx (best_idx)
    );
    // found is presented from the tracker directly during DONE so it is valid with done.
    assign bus.hyp_idx       = hyp_q;
    assign bus.busy          = state_q != IDLE;
    assign bus.done          = state_q == DONE;
    assign bus.found         = state_q == DONE ? hit : found_q;
    assign bus.best_idx      = best_idx;
    assign bus.best_metric   = best;
    assign bus.second_metric = second;
endmodule

// File: tb/tb_sss_peak_detector.sv
// tb_sss_peak_detector: table-driven searches with a done-time scoreboard, plus idle and reset corner cases.
module tb_sss_peak_detector;
    import sss_pkg::*;
    localparam int NUM_HYP = NUM_NID1;
    typedef struct {
        int          pat;
        logic [31:0] thr;
        bit          gap;
        logic [7:0]  e_idx;
        logic [31:0] e_best;
        logic [31:0] e_second;
        bit          e_found;
    } vec_t;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0, failures = 0, done_cnt = 0;
    vec_t sb[$];
    vec_t tbl[7];
    always #5 clk = ~clk;
    sss_peak_detector_if #(.CORR_W(CORR_W), .IDX_W(IDX_W)) bus ();
    sss_peak_detector #(.NUM_HYP(NUM_HYP), .CORR_W(CORR_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", n, a, e);
        end
    endtask
    function automatic logic [31:0] metric(input int pat, input logic [7:0] i);
        case (pat)
            0:       return i == 8'd37 ? 32'd1000 : 32'(i);
            1:       return (i == 8'd10 || i == 8'd90) ? 32'd800 : 32'd5;
            2:       return 32'd100;
            3:       return 32'd40;
            default: return 32'd1000 - 32'(i);
        endcase
    endfunction
    always @(negedge clk) begin
        vec_t e;
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("best_idx", 32'(bus.best_idx), 32'(e.e_idx));
                chk("best_metric", bus.best_metric, e.e_best);
                chk("second_metric", bus.second_metric, e.e_second);
                chk("found_at_done", 32'(bus.found), 32'(e.e_found));
                chk("busy_at_done", 32'(bus.busy), 32'd1);
            end
        end
    end
    task automatic zero_outputs(input string n);
        chk({n, "_hyp"}, 32'(bus.hyp_idx), 32'd0);
        chk({n, "_busy"}, 32'(bus.busy), 32'd0);
        chk({n, "_done"}, 32'(bus.done), 32'd0);
        chk({n, "_found"}, 32'(bus.found), 32'd0);
        chk({n, "_bidx"}, 32'(bus.best_idx), 32'd0);
        chk({n, "_best"}, bus.best_metric, 32'd0);
        chk({n, "_second"}, bus.second_metric, 32'd0);
    endtask
    task automatic run(input vec_t v);
        int cyc = 0, k = 0, d0;
        bit mid = 0;
        d0 = done_cnt;
        @(negedge clk);
        bus.threshold = v.thr;
        bus.start     = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("hyp_after_start", 32'(bus.hyp_idx), 32'd0);
        while (bus.done !== 1'b1 && cyc < 2000) begin
            bus.corr_valid         = !v.gap || (k % 3 == 2);
            bus.correlation_result = metric(v.pat, bus.hyp_idx);
            k++;
            if (v.gap && !mid && bus.hyp_idx == 8'd50) begin
                bus.start     = 1'b1;
                bus.threshold = '1;
                mid           = 1;
            end else bus.start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        bus.corr_valid = 1'b0;
        bus.start      = 1'b0;
        if (cyc >= 2000) chk("done_timeout", 32'(cyc), 32'd0);
        if (!v.gap) chk("search_len", 32'(cyc), 32'(NUM_HYP));
        @(negedge clk);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("hyp_hold", 32'(bus.hyp_idx), 32'(NUM_HYP - 1));
        chk("found_hold", 32'(bus.found), 32'(v.e_found));
        chk("best_hold", bus.best_metric, v.e_best);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
    endtask
    initial begin
        int cyc, d0;
        bus.start = 1'b0;
        bus.threshold = '0;
        bus.corr_valid = 1'b0;
        bus.correlation_result = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        zero_outputs("reset");
        bus.corr_valid = 1'b1;
        bus.correlation_result = 32'd500;
        repeat (3) @(negedge clk);
        bus.corr_valid = 1'b0;
        zero_outputs("idle_valid");
        tbl[0] = '{0, 32'd500, 1'b0, 8'd37, 32'd1000, 32'd167, 1'b1};
        tbl[1] = '{1, 32'd500, 1'b0, 8'd10, 32'd800, 32'd5, 1'b1};
        tbl[2] = '{2, 32'd50, 1'b0, 8'd0, 32'd100, 32'd0, 1'b1};
        tbl[3] = '{3, 32'd50, 1'b0, 8'd0, 32'd40, 32'd0, 1'b0};
        tbl[4] = '{0, 32'd500, 1'b1, 8'd37, 32'd1000, 32'd167, 1'b1};
        tbl[5] = '{5, 32'd2000, 1'b0, 8'd0, 32'd1000, 32'd999, 1'b0};
        tbl[6] = '{0, 32'd1000, 1'b0, 8'd37, 32'd1000, 32'd167, 1'b1};
        for (int i = 0; i < 7; i++) run(tbl[i]);
        @(negedge clk);
        bus.threshold = 32'd500;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.corr_valid = 1'b1;
        cyc = 0;
        while (bus.hyp_idx != 8'd80 && cyc < 500) begin
            bus.correlation_result = metric(0, bus.hyp_idx);
            @(negedge clk);
            cyc++;
        end
        chk("reach_hyp80", 32'(cyc < 500), 32'd1);
        reset = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        reset = 1'b0;
        bus.corr_valid = 1'b0;
        zero_outputs("mid_reset");
        repeat (200) @(negedge clk);
        chk("no_done_after_reset", 32'(done_cnt), 32'(d0));
        run(tbl[0]);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sss_peak_detector.md
# sss_peak_detector

Downstream of the SSS correlator: steps the correlator through all N_ID1 hypotheses, consumes one `correlation_result` per hypothesis, tracks the largest and second-largest metrics, and declares a detection. Its `hyp_idx` output drives the local-SSS selection feeding the correlator. Its `best_idx` output is the detected cell-ID group for the cell-search controller.

## Interface
- `NUM_HYP`, 168: number of hypotheses searched (indices 0..NUM_HYP-1).
- `CORR_W`, 32: width of the correlation metric.
- `IDX_W`, 8: width of hypothesis index; must satisfy 2^IDX_W >= NUM_HYP.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state and outputs.
- `start`  in  1  one-cycle pulse; begins a new search (ignored while `busy`).
- `threshold`  in  CORR_W  minimum peak for detection, unsigned; sampled on accepted `start`.
- `corr_valid`  in  1  `correlation_result` is valid for the current `hyp_idx`.
- `correlation_result`  in  CORR_W  unsigned metric from correlator.
- `hyp_idx`  out  IDX_W  hypothesis currently requested from the correlator.
- `busy`  out  1  search in progress.
- `done`  out  1  one-cycle pulse when results are final.
- `found`  out  1  detection flag, valid from `done` until next accepted `start`.
- `best_idx`  out  IDX_W  index of largest metric.
- `best_metric`  out  CORR_W  largest metric.
- `second_metric`  out  CORR_W  second-largest metric.

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE: `start`=1 → SEARCH; clear `hyp_idx`, `best_*`, `second_metric`, `found`; latch `threshold`. `corr_valid` ignored.
- SEARCH: `hyp_idx` held stable until `corr_valid`=1. On accept:
  - value > best → second ← best, best ← value, best_idx ← hyp_idx.
  - else value > second → second ← value.
  - Strict compares: equal metrics keep the lower index, and an equal value does not displace second.
  - If hyp_idx = NUM_HYP-1 → DONE; else hyp_idx+1.
- DONE (one cycle): `found` ← (best >= latched threshold) AND (best > second); `done`=1; → IDLE.
- Outputs hold after DONE until next accepted `start`; `hyp_idx` holds NUM_HYP-1.
- `start` during SEARCH/DONE ignored; latched threshold unaffected.
- Multiple `corr_valid` cycles back-to-back: each accepted, one per hypothesis.
- NUM_HYP=1: second stays 0; found = best >= threshold AND best > 0.
- Arithmetic: unsigned compares only, no accumulation, no overflow.

## Timing
- Reset values: `hyp_idx`=0, `busy`=0, `done`=0, `found`=0, `best_idx`=0, `best_metric`=0, `second_metric`=0, state IDLE.
- `start` at cycle T → `busy`=1, `hyp_idx`=0 at T+1.
- `corr_valid` at cycle T (not last) → `hyp_idx` increments at T+1; best/second updated at T+1.
- Last accept at T → DONE at T+1 with `done`=1 and final `best_*`; `found` registered at T+2. Spec: `found` is combinationally derived in DONE so it is valid with `done` at T+1; `busy`=0 at T+2.
- Minimum search length: NUM_HYP+2 cycles from `start`.
- `reset` mid-search: next cycle all outputs at reset values, no `done` pulse.

## Structure
- Shared package `sss_pkg`: SSS_LEN=62, NUM_NID1=168, CORR_W=32, IDX_W=8, state enum {IDLE, SEARCH, DONE}; correlator and this block both import it.
- One sub-module: `sss_peak_tracker` (clear, update strobe, value, index → best/second/best_idx registers).
- FSM, index counter, and threshold latch stay in the top module.

## Test plan
- Reset then idle: all outputs 0; `corr_valid`=1 with value 500 in IDLE → no change.
- NUM_HYP=168, metric = index except idx 37 = 1000, threshold 500 → `best_idx`=37, `best_metric`=1000, `second_metric`=167, `found`=1, `done` once.
- Tie: idx 10 and idx 90 both 800, others 5 → `best_idx`=10, `second_metric`=5 (equal not promoted), `found`=1.
- All metrics 100, threshold 50 → `best_idx`=0, `found`=1 (second=0 < best); all metrics 40, threshold 50 → `found`=0.
- `corr_valid` gapped (every 3rd cycle), `start` pulsed mid-search → ignored, results identical to gapless run.
- `reset` asserted at hyp_idx 80 → outputs cleared next cycle, no `done`; fresh `start` completes a normal search.
